// File: rtl/frame_smoother.sv
// -----------------------------------------------------------------------------
// frame_smoother
//   Causal boxcar moving-average filter for framed, signed AXI-Stream samples.
//   Window length N = 2**N_LOG2. The history is re-primed with the first
//   sample of every frame (tuser), so frames never bleed into each other.
//   Beats arriving outside a frame are discarded and flagged in `dropped`.
//
// Handshake: a beat moves on a channel in a cycle where ce && tvalid && tready.
//   tvalid is never withdrawn before its beat moves. While a beat is held,
//   its payload (tdata/tuser/tlast) stays stable. The output side is a single
//   register with pass-through backpressure: tready_s = !tvalid_m || tready_m.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ce               clock enable; all state holds while low
//   tdata_s/tuser_s/tlast_s/tvalid_s/tready_s   input stream (slave side)
//   tdata_m/tuser_m/tlast_m/tvalid_m/tready_m   smoothed stream (master side)
//   dropped          sticky: a beat was discarded outside a frame
//   dbg_state        FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module frame_smoother #(
  parameter int DW     = 16,
  parameter int N_LOG2 = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [DW-1:0] tdata_s,
  input  logic          tuser_s,
  input  logic          tlast_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [DW-1:0] tdata_m,
  output logic          tuser_m,
  output logic          tlast_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  output logic          dropped,
  output logic          dbg_state
);

  localparam int N  = 1 << N_LOG2;
  // Sum of N samples of DW bits needs exactly DW+N_LOG2 bits: never overflows.
  localparam int SW = DW + N_LOG2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [DW-1:0]        r_hist [N];   // [0] newest, [N-1] oldest
  logic signed [SW-1:0] r_sum;

  logic [DW-1:0]        r_data;
  logic                 r_user;
  logic                 r_last;
  logic                 r_valid;
  logic                 r_dropped;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_produce;
  logic                 w_drop;
  logic signed [SW-1:0] w_x_ext;
  logic signed [SW-1:0] w_old_ext;
  logic signed [SW-1:0] w_sum_next;
  logic [DW-1:0]        w_result;

  assign w_ready   = !r_valid || tready_m;
  assign w_accept  = ce && tvalid_s && w_ready;
  // A frame-start beat is always in-frame; otherwise only RUN beats count.
  assign w_produce = w_accept && (tuser_s || (r_state == S_RUN));
  assign w_drop    = w_accept && !tuser_s && (r_state == S_IDLE);

  assign w_x_ext   = SW'($signed(tdata_s));
  assign w_old_ext = SW'($signed(r_hist[N-1]));

  always_comb begin
    w_sum_next = r_sum + w_x_ext - w_old_ext;
    if (tuser_s) begin
      // Re-prime: every history slot holds x, so the sum is x*N.
      w_sum_next = w_x_ext <<< N_LOG2;
    end
  end

  // Arithmetic shift floors toward -inf; the mean of DW-bit samples fits DW.
  assign w_result = DW'(w_sum_next >>> N_LOG2);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_next = r_state;
    if (w_produce) begin
      // tlast ends the frame even on a one-sample (tuser+tlast) frame.
      w_state_next = tlast_s ? S_IDLE : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_state_next;
    end
  end

  // ------------------------------------------------------- history / sum
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_produce) begin
      r_sum <= w_sum_next;
      if (tuser_s) begin
        for (int i = 0; i < N; i++) begin
          r_hist[i] <= tdata_s;
        end
      end else begin
        for (int i = N - 1; i > 0; i--) begin
          r_hist[i] <= r_hist[i-1];
        end
        r_hist[0] <= tdata_s;
      end
    end
  end

  // ------------------------------------------------------ output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
      r_last  <= 1'b0;
    end else if (ce) begin
      if (w_produce) begin
        r_valid <= 1'b1;
        r_data  <= w_result;
        r_user  <= tuser_s;
        r_last  <= tlast_s;
      end else if (tready_m) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped <= 1'b0;
    end else if (w_drop) begin
      r_dropped <= 1'b1;
    end
  end

  assign tready_s  = w_ready;
  assign tvalid_m  = r_valid;
  assign tdata_m   = r_data;
  assign tuser_m   = r_user;
  assign tlast_m   = r_last;
  assign dropped   = r_dropped;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_frame_smoother.sv
// -----------------------------------------------------------------------------
// tb_frame_smoother
//   Table-driven bench for frame_smoother (DW=16, N=8). Each vector carries
//   the input beat, whether it should produce an output, the expected output
//   and the expected dropped flag / FSM state after the beat is accepted.
//   Expected outputs go into exp_q when the beat is accepted and are popped
//   by the monitor when the output handshake happens.
// -----------------------------------------------------------------------------
module tb_frame_smoother;

  localparam int DW = 16;
  localparam int W  = DW + 2;   // {tuser, tlast, tdata}

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b1;
  logic          ce       = 1'b1;
  logic [DW-1:0] tdata_s  = '0;
  logic          tuser_s  = 1'b0;
  logic          tlast_s  = 1'b0;
  logic          tvalid_s = 1'b0;
  logic          tready_s;
  logic [DW-1:0] tdata_m;
  logic          tuser_m;
  logic          tlast_m;
  logic          tvalid_m;
  logic          tready_m = 1'b1;
  logic          dropped;
  logic          dbg_state;

  logic          bp_on       = 1'b0;
  logic          tready_level = 1'b1;

  frame_smoother #(.DW(DW), .N_LOG2(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .tdata_s   (tdata_s),
    .tuser_s   (tuser_s),
    .tlast_s   (tlast_s),
    .tvalid_s  (tvalid_s),
    .tready_s  (tready_s),
    .tdata_m   (tdata_m),
    .tuser_m   (tuser_m),
    .tlast_m   (tlast_m),
    .tvalid_m  (tvalid_m),
    .tready_m  (tready_m),
    .dropped   (dropped),
    .dbg_state (dbg_state)
  );

  // Sole driver of tready_m: random while bp_on, else the requested level.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready_m = bp_on ? 1'($urandom_range(0, 1)) : tready_level;
    end
  end

  // ------------------------------------------------------------ checking
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge; a handshake seen here completes
  // at the next rising edge.
  logic         held_v = 1'b0;
  logic [W-1:0] held_w = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else if (ce) begin
        if (held_v && tvalid_m) begin
          check("stall_hold", {14'b0, tuser_m, tlast_m, tdata_m}, {14'b0, held_w});
        end
        if (tvalid_m && !tready_m) begin
          check("stall_tready_s", {31'b0, tready_s}, 32'd0);
        end
        held_v = tvalid_m && !tready_m;
        held_w = {tuser_m, tlast_m, tdata_m};
        if (tvalid_m && tready_m) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {14'b0, tuser_m, tlast_m, tdata_m}, 32'hFFFF_FFFF);
          end else begin
            check("out_beat", {14'b0, tuser_m, tlast_m, tdata_m}, {14'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- vectors
  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic          prod;
    logic [DW-1:0] e;
    logic          eu;
    logic          el;
    logic          xdrop;
    logic          xst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input bit u, input bit l, input bit prod,
                              input int e, input bit eu, input bit el,
                              input bit xdrop, input bit xst);
    vec_t v;
    v.d = d[DW-1:0];  v.u = u;   v.l = l;   v.prod = prod;
    v.e = e[DW-1:0];  v.eu = eu; v.el = el; v.xdrop = xdrop; v.xst = xst;
    return v;
  endfunction

  // ------------------------------------------------------------- drivers
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int guard = 0;
    tdata_s  = v.d;
    tuser_s  = v.u;
    tlast_s  = v.l;
    tvalid_s = 1'b1;
    forever begin
      @(negedge clk);
      if (tready_s && ce) break;
      guard++;
      if (guard > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (v.prod) exp_q.push_back({v.eu, v.el, v.e});
    @(posedge clk);
    #1;
    tvalid_s = 1'b0;
    check("dropped_after_beat", {31'b0, dropped}, {31'b0, v.xdrop});
    check("state_after_beat", {31'b0, dbg_state}, {31'b0, v.xst});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tvalid_m) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'b0, (exp_q.size() != 0 || tvalid_m)}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  initial begin
    // Step response: 0 then 15 x 80.
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 1));
    for (int k = 1; k <= 15; k++) begin
      vecs.push_back(mk(80, 0, k == 15, 1, (k < 8) ? 10 * k : 80, 0, k == 15, 0, k != 15));
    end
    // Floor rounding: -8>>>3 = -1, then -7>>>3 = -1.
    vecs.push_back(mk(-1, 1, 0, 1, -1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, -1, 0, 1, 0, 0));
    // Most negative sample, no overflow.
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(-32768, k == 0, k == 3, 1, -32768, k == 0, k == 3, 0, k != 3));
    end
    // Three out-of-frame beats: discarded, dropped set.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(5 + k, 0, k == 2, 0, 0, 0, 0, 1, 0));
    end
    // Frame A with a re-prime in the middle.
    vecs.push_back(mk(100, 1, 0, 1, 100, 1, 0, 1, 1));
    vecs.push_back(mk(100, 0, 0, 1, 100, 0, 0, 1, 1));
    vecs.push_back(mk(100, 0, 0, 1, 100, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0));
    // One-sample frame.
    vecs.push_back(mk(42, 1, 1, 1, 42, 1, 1, 1, 0));

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_tvalid_m", {31'b0, tvalid_m}, 32'd0);
    check("rst_tdata_m", {16'b0, tdata_m}, 32'd0);
    check("rst_tuser_m", {31'b0, tuser_m}, 32'd0);
    check("rst_tlast_m", {31'b0, tlast_m}, 32'd0);
    check("rst_dropped", {31'b0, dropped}, 32'd0);
    check("rst_tready_s", {31'b0, tready_s}, 32'd1);
    check("rst_state", {31'b0, dbg_state}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i]);
    end
    drain("drain_table");

    // Ramp 0..9 under random backpressure; expected equals the no-stall run.
    begin
      int ramp_exp[10] = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5};
      bp_on = 1'b1;
      for (int k = 0; k < 10; k++) begin
        send(mk(k, k == 0, k == 9, 1, ramp_exp[k], k == 0, k == 9, 1, k != 9));
      end
      drain("drain_ramp");
      bp_on = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Clock enable low: the output register holds even with tready_m high.
    send(mk(3, 1, 1, 1, 3, 1, 1, 1, 0));
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ce_hold_valid", {31'b0, tvalid_m}, 32'd1);
      check("ce_hold_data", {16'b0, tdata_m}, 32'd3);
    end
    @(posedge clk);
    #1;
    ce = 1'b1;
    drain("drain_ce");

    // Reset in the middle of a frame with a stalled output beat.
    tready_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(mk(7, 1, 0, 1, 7, 1, 0, 1, 1));
    @(negedge clk);
    check("pre_rst_valid", {31'b0, tvalid_m}, 32'd1);
    check("pre_rst_data", {16'b0, tdata_m}, 32'd7);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_tvalid_m", {31'b0, tvalid_m}, 32'd0);
    check("mid_rst_tdata_m", {16'b0, tdata_m}, 32'd0);
    check("mid_rst_tuser_m", {31'b0, tuser_m}, 32'd0);
    check("mid_rst_tlast_m", {31'b0, tlast_m}, 32'd0);
    check("mid_rst_dropped", {31'b0, dropped}, 32'd0);
    check("mid_rst_tready_s", {31'b0, tready_s}, 32'd1);
    check("mid_rst_state", {31'b0, dbg_state}, 32'd0);
    tready_level = 1'b1;
    send(mk(9, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_output", {31'b0, tvalid_m}, 32'd0);
    end
    check("post_rst_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
